// File: rtl/alu_arbiter_2ch.sv
// alu_arbiter_2ch
//   Round-robin arbiter and sequencer that shares one 8-bit ALU between two
//   requesters. A granted request has its opcode and operands registered onto
//   the ALU drive ports. The block waits ALU_LATENCY cycles, then captures
//   alu_out/carry into the granted channel's response register. That response
//   is held until the requester consumes it. Only one transaction is in
//   flight at a time.
//
// Parameters
//   ALU_LATENCY : register stages inside the ALU (0..6)
//
// Ports
//   CLK, RESET                          : clock, synchronous active-high reset
//   req{0,1}_valid/ready                : request handshake per channel
//   req{0,1}_opcode/_a/_b               : request opcode and operands
//   rsp{0,1}_valid/ready                : response handshake per channel
//   rsp{0,1}_data/_carry                : response result and carry
//   opcode, operand_a, operand_b        : registered drive to the ALU
//   alu_out, carry                      : ALU result inputs
//   busy                                : high whenever not IDLE
//   grant_id                            : channel owning the current transaction
module alu_arbiter_2ch #(
  parameter int ALU_LATENCY = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_opcode,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_data,
  output logic       rsp0_carry,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_opcode,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_data,
  output logic       rsp1_carry,
  output logic [7:0] opcode,
  output logic [7:0] operand_a,
  output logic [7:0] operand_b,
  input  logic [7:0] alu_out,
  input  logic       carry,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t     state_reg, state_next;
  logic       last_reg;
  logic [2:0] cnt_reg;
  logic       grant_reg;
  logic [7:0] opcode_reg, operand_a_reg, operand_b_reg;
  logic [1:0] rsp_valid_reg;
  logic [1:0] rsp_carry_reg;
  logic [7:0] rsp_data_reg [2];

  logic [1:0] req_valid;
  logic [1:0] rsp_ready;
  logic       winner;
  logic       accept;
  logic       handshake;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // With both channels valid the one not served last wins; otherwise the
  // only valid channel wins (channel 1 iff it is the valid one).
  assign winner    = (&req_valid) ? ~last_reg : req1_valid;
  assign accept    = (state_reg == IDLE) && (|req_valid) && !RESET;
  assign handshake = (state_reg == RESP) && rsp_ready[grant_reg];

  assign req0_ready = accept && !winner;
  assign req1_ready = accept && winner;

  // Status outputs are forced low while reset is held, not just after the edge.
  assign busy     = (state_reg != IDLE) && !RESET;
  assign grant_id = grant_reg && !RESET;

  assign opcode    = opcode_reg;
  assign operand_a = operand_a_reg;
  assign operand_b = operand_b_reg;

  assign rsp0_valid = rsp_valid_reg[0];
  assign rsp0_data  = rsp_data_reg[0];
  assign rsp0_carry = rsp_carry_reg[0];
  assign rsp1_valid = rsp_valid_reg[1];
  assign rsp1_data  = rsp_data_reg[1];
  assign rsp1_carry = rsp_carry_reg[1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    if (cnt_reg == 3'd0) state_next = RESP;
      RESP:    if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      cnt_reg       <= 3'd0;
      grant_reg     <= 1'b0;
      opcode_reg    <= 8'd0;
      operand_a_reg <= 8'd0;
      operand_b_reg <= 8'd0;
      rsp_valid_reg <= 2'b00;
      rsp_carry_reg <= 2'b00;
      rsp_data_reg[0] <= 8'd0;
      rsp_data_reg[1] <= 8'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            grant_reg     <= winner;
            opcode_reg    <= winner ? req1_opcode : req0_opcode;
            operand_a_reg <= winner ? req1_a : req0_a;
            operand_b_reg <= winner ? req1_b : req0_b;
            cnt_reg       <= 3'(ALU_LATENCY);
          end
        end
        WAIT: begin
          if (cnt_reg != 3'd0) begin
            cnt_reg <= cnt_reg - 3'd1;
          end else begin
            rsp_valid_reg[grant_reg] <= 1'b1;
            rsp_data_reg[grant_reg]  <= alu_out;
            rsp_carry_reg[grant_reg] <= carry;
          end
        end
        RESP: begin
          // Clearing data/carry too keeps the idle channel's outputs at zero.
          if (handshake) begin
            rsp_valid_reg[grant_reg] <= 1'b0;
            rsp_data_reg[grant_reg]  <= 8'd0;
            rsp_carry_reg[grant_reg] <= 1'b0;
            last_reg                 <= grant_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter_2ch.sv
module tb_alu_arbiter_2ch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance with ALU_LATENCY = 0 ----------------
  logic       req0_valid = 0, req1_valid = 0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_opcode = 0, req0_a = 0, req0_b = 0;
  logic [7:0] req1_opcode = 0, req1_a = 0, req1_b = 0;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready = 1, rsp1_ready = 1;
  logic [7:0] rsp0_data, rsp1_data;
  logic       rsp0_carry, rsp1_carry;
  logic [7:0] opcode, operand_a, operand_b, alu_out;
  logic       carry, busy, grant_id;

  assign {carry, alu_out} = 9'(operand_a) + 9'(operand_b);

  alu_arbiter_2ch #(.ALU_LATENCY(0)) u_dut0 (
    .CLK(clk), .RESET(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_carry(rsp0_carry),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_carry(rsp1_carry),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .alu_out(alu_out), .carry(carry), .busy(busy), .grant_id(grant_id)
  );

  // ---------------- instance with ALU_LATENCY = 2 ----------------
  logic       b_req0_valid = 0, b_req1_valid = 0;
  logic       b_req0_ready, b_req1_ready;
  logic [7:0] b_req0_opcode = 0, b_req0_a = 0, b_req0_b = 0;
  logic [7:0] b_req1_opcode = 0, b_req1_a = 0, b_req1_b = 0;
  logic       b_rsp0_valid, b_rsp1_valid;
  logic       b_rsp0_ready = 1, b_rsp1_ready = 1;
  logic [7:0] b_rsp0_data, b_rsp1_data;
  logic       b_rsp0_carry, b_rsp1_carry;
  logic [7:0] b_opcode, b_operand_a, b_operand_b, b_alu_out;
  logic       b_carry, b_busy, b_grant_id;
  logic [8:0] b_pipe1, b_pipe2;

  always @(posedge clk) begin
    b_pipe1 <= 9'(b_operand_a) + 9'(b_operand_b);
    b_pipe2 <= b_pipe1;
  end
  assign {b_carry, b_alu_out} = b_pipe2;

  alu_arbiter_2ch #(.ALU_LATENCY(2)) u_dut2 (
    .CLK(clk), .RESET(rst),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_opcode(b_req0_opcode),
    .req0_a(b_req0_a), .req0_b(b_req0_b),
    .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready), .rsp0_data(b_rsp0_data),
    .rsp0_carry(b_rsp0_carry),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_opcode(b_req1_opcode),
    .req1_a(b_req1_a), .req1_b(b_req1_b),
    .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready), .rsp1_data(b_rsp1_data),
    .rsp1_carry(b_rsp1_carry),
    .opcode(b_opcode), .operand_a(b_operand_a), .operand_b(b_operand_b),
    .alu_out(b_alu_out), .carry(b_carry), .busy(b_busy), .grant_id(b_grant_id)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp0_q[$];   // {carry, data} expected on channel 0
  logic [8:0] exp1_q[$];   // {carry, data} expected on channel 1
  bit         grant_q[$];  // expected grant order

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or response.
  initial begin
    logic [8:0] e;
    bit         g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req0_ready || req1_ready) begin
          check("single_ready", 16'(req0_ready && req1_ready), 16'd0);
          if (grant_q.size() == 0) begin
            check("unexpected_grant", 16'(req1_ready), 16'hFFFF);
          end else begin
            g = grant_q.pop_front();
            check("grant_order", 16'(req1_ready), 16'(g));
            $display("grant ch%0d", req1_ready);
          end
        end
        if (rsp0_valid && rsp0_ready) begin
          check("rsp0_grant_id", 16'(grant_id), 16'd0);
          if (exp0_q.size() == 0) begin
            check("unexpected_rsp0", 16'(rsp0_data), 16'hFFFF);
          end else begin
            e = exp0_q.pop_front();
            check("rsp0_result", 16'({rsp0_carry, rsp0_data}), 16'(e));
            $display("rsp ch0 data=%0d carry=%0d", rsp0_data, rsp0_carry);
          end
        end
        if (rsp1_valid && rsp1_ready) begin
          check("rsp1_grant_id", 16'(grant_id), 16'd1);
          if (exp1_q.size() == 0) begin
            check("unexpected_rsp1", 16'(rsp1_data), 16'hFFFF);
          end else begin
            e = exp1_q.pop_front();
            check("rsp1_result", 16'({rsp1_carry, rsp1_data}), 16'(e));
            $display("rsp ch1 data=%0d carry=%0d", rsp1_data, rsp1_carry);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                      input bit expect_rsp);
    int n;
    req0_opcode = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    if (expect_rsp) exp0_q.push_back(9'(a) + 9'(b));
    n = 0;
    forever begin
      @(negedge clk);
      if (req0_ready) break;
      n++;
      if (n > 100) begin
        check("req0_accept_timeout", 16'(n), 16'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
  endtask

  task automatic req1(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                      input bit expect_rsp);
    int n;
    req1_opcode = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    if (expect_rsp) exp1_q.push_back(9'(a) + 9'(b));
    n = 0;
    forever begin
      @(negedge clk);
      if (req1_ready) break;
      n++;
      if (n > 100) begin
        check("req1_accept_timeout", 16'(n), 16'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    if (n >= 100) check("idle_timeout", 16'(busy), 16'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Holds rsp0_ready low through RESP and checks the response stays put.
  task automatic stall_checker();
    int n;
    logic [7:0] d;
    logic c;
    n = 0;
    while (!rsp0_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_rsp0_seen", 16'(rsp0_valid), 16'd1);
    d = rsp0_data;
    c = rsp0_carry;
    check("stall_data", 16'(d), 16'd110);
    check("stall_carry", 16'(c), 16'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold_valid", 16'(rsp0_valid), 16'd1);
      check("stall_hold_data", 16'({rsp0_carry, rsp0_data}), 16'({c, d}));
      check("stall_req1_ready", 16'(req1_ready), 16'd0);
    end
    @(posedge clk);
    #1;
    rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ch1_first_idle", 16'(req1_ready), 16'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_grant_id", 16'(grant_id), 16'd0);
    check("rst_operands", 16'({operand_a, operand_b}), 16'd0);
    check("rst_opcode", 16'(opcode), 16'd0);
    check("rst_rsp_valid", 16'({rsp1_valid, rsp0_valid}), 16'd0);
    check("rst_rsp_data", 16'({rsp1_data, rsp0_data}), 16'd0);

    // Single ch0 request: 200 + 100 = 300 -> data 44, carry 1
    sync();
    grant_q.push_back(1'b0);
    req0(8'h01, 8'd200, 8'd100, 1'b1);
    @(negedge clk);
    check("t1_busy_wait", 16'(busy), 16'd1);
    check("t1_rsp0_early", 16'(rsp0_valid), 16'd0);
    check("t1_opcode", 16'(opcode), 16'h01);
    check("t1_operands", 16'({operand_a, operand_b}), 16'({8'd200, 8'd100}));
    @(negedge clk);
    check("t1_rsp0_valid", 16'(rsp0_valid), 16'd1);
    check("t1_rsp0_value", 16'({rsp0_carry, rsp0_data}), 16'({1'b1, 8'd44}));
    check("t1_rsp1_idle", 16'({rsp1_valid, rsp1_carry, rsp1_data}), 16'd0);
    wait_idle();

    // Both valid on first cycle after reset: ch0 (3) then ch1 (7)
    do_reset();
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b1);
    fork
      req0(8'h02, 8'd1, 8'd2, 1'b1);
      req1(8'h03, 8'd3, 8'd4, 1'b1);
    join
    wait_idle();

    // Continuous valid on both channels: grants alternate 0,1,0,1,0,1
    sync();
    for (int i = 0; i < 3; i++) begin
      grant_q.push_back(1'b0);
      grant_q.push_back(1'b1);
    end
    fork
      begin
        req0(8'h10, 8'd10, 8'd20, 1'b1);
        req0(8'h11, 8'd100, 8'd200, 1'b1);
        req0(8'h12, 8'd255, 8'd255, 1'b1);
      end
      begin
        req1(8'h20, 8'd5, 8'd6, 1'b1);
        req1(8'h21, 8'd128, 8'd128, 1'b1);
        req1(8'h22, 8'd7, 8'd250, 1'b1);
      end
    join
    wait_idle();

    // rsp0_ready held low in RESP; ch1 waits for the next IDLE
    sync();
    rsp0_ready = 1'b0;
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b1);
    fork
      req0(8'h30, 8'd50, 8'd60, 1'b1);
      req1(8'h31, 8'd70, 8'd80, 1'b1);
      stall_checker();
    join
    wait_idle();

    // Reset during WAIT abandons the transaction
    sync();
    grant_q.push_back(1'b0);
    req0(8'h40, 8'd9, 8'd9, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_during_busy", 16'(busy), 16'd0);
    check("rstw_during_ready", 16'({req1_ready, req0_ready}), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstw_outputs", 16'({busy, grant_id, rsp0_valid, rsp1_valid}), 16'd0);
    check("rstw_operands", 16'({operand_a, operand_b}), 16'd0);
    check("rstw_opcode_data", 16'({opcode, rsp0_data}), 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstw_no_rsp", 16'({rsp1_valid, rsp0_valid}), 16'd0);
    end
    sync();
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b1);
    fork
      req0(8'h41, 8'd11, 8'd22, 1'b1);
      req1(8'h42, 8'd33, 8'd44, 1'b1);
    join
    wait_idle();

    // ALU_LATENCY = 2: 255 + 1 -> data 0, carry 1, valid in cycle E0+4
    sync();
    b_req0_opcode = 8'h5A; b_req0_a = 8'd255; b_req0_b = 8'd1; b_req0_valid = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!b_req0_ready && n < 50);
      check("lat2_accept", 16'(b_req0_ready), 16'd1);
    end
    @(posedge clk);
    #1;
    b_req0_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("lat2_rsp_early", 16'(b_rsp0_valid), 16'd0);
      check("lat2_operands", 16'({b_operand_a, b_operand_b}), 16'({8'd255, 8'd1}));
    end
    @(negedge clk);
    check("lat2_rsp_valid", 16'(b_rsp0_valid), 16'd1);
    check("lat2_result", 16'({b_rsp0_carry, b_rsp0_data}), 16'({1'b1, 8'd0}));
    check("lat2_rsp1_idle", 16'(b_rsp1_valid), 16'd0);
    check("lat2_grant", 16'(b_grant_id), 16'd0);
    @(negedge clk);
    check("lat2_done", 16'({b_busy, b_rsp0_valid}), 16'd0);

    // Everything expected must have been observed
    repeat (3) @(negedge clk);
    check("queues_drained", 16'(exp0_q.size() + exp1_q.size() + grant_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter_2ch.md
# alu_arbiter_2ch

Two-channel arbiter and sequencer for the shared 8-bit ALU. Two independent requesters, for example a control sequencer and a test or debug port, submit opcode/operand transactions over valid/ready handshakes. The block grants the ALU to one requester at a time using round-robin priority, drives the ALU operand and opcode ports, and waits a parameterised latency. It then captures `alu_out` and `carry` and returns them on the granting channel's response handshake.

## Interface
Parameters:
- `ALU_LATENCY`, default 0: number of register stages inside the ALU; legal range 0..6.

Ports:
- `CLK`, in, 1: single clock; all logic is on the rising edge.
- `RESET`, in, 1: synchronous, active-high.
- `req0_valid`, in, 1: channel 0 request valid.
- `req0_ready`, out, 1: channel 0 request accepted this cycle.
- `req0_opcode`, `req0_a`, `req0_b`, in, 8 each: channel 0 opcode and operands.
- `rsp0_valid`, out, 1: channel 0 result valid.
- `rsp0_ready`, in, 1: channel 0 result consumed.
- `rsp0_data`, out, 8: channel 0 result.
- `rsp0_carry`, out, 1: channel 0 carry.
- `req1_*` and `rsp1_*`: identical to the channel 0 ports, for channel 1.
- `opcode`, `operand_a`, `operand_b`, out, 8 each: registered drive to the ALU.
- `alu_out`, in, 8: ALU result.
- `carry`, in, 1: ALU carry.
- `busy`, out, 1: high in any state other than IDLE.
- `grant_id`, out, 1: channel that owns the current transaction.

## Operation
- FSM states: IDLE, WAIT, RESP. Only one transaction is outstanding at a time.
- IDLE:
  - If any `reqN_valid` is high, choose a winner and assert `reqN_ready` combinationally for the winner only.
  - Winner rule: if only one channel is valid, it wins. If both are valid, the channel that was not served last wins. The `last` pointer resets to 1, so channel 0 wins first.
  - On the accept edge, register the winner's opcode, a and b onto `opcode`, `operand_a` and `operand_b`. Set `grant_id`, load `cnt = ALU_LATENCY`, and go to WAIT.
- WAIT:
  - If `cnt != 0`, decrement it.
  - If `cnt == 0`, capture `alu_out` and `carry` into the granted channel's response register, set its `rspN_valid`, and go to RESP.
- RESP:
  - Hold `rspN_valid`, `rspN_data` and `rspN_carry` stable until `rspN_ready` is high.
  - On the handshake edge, clear `rspN_valid`, set `last = grant_id`, and go to IDLE.
  - No request is accepted in RESP.
- Signals held stable: `opcode`, `operand_a` and `operand_b` keep their values from accept until the next accept. The non-granted channel's `rsp` outputs stay at 0.
- Requester rule: a requester holds its opcode and operands stable while `valid && !ready`. The block never drops a valid request.
- Data path: opcode is passed through opaque; the block does not interpret opcode values. No arithmetic is performed; widths pass through 8 bits to 8 bits.

## Timing
- Reset (synchronous, on any edge with `RESET` = 1):
  - State becomes IDLE; `last` = 1; `cnt` = 0.
  - `opcode`, `operand_a` and `operand_b` become 0.
  - `rsp0_valid`, `rsp1_valid`, `rsp*_data` and `rsp*_carry` become 0.
  - `busy` = 0, `grant_id` = 0, and both `req*_ready` = 0 while `RESET` is high.
- Reset mid-transaction (WAIT or RESP): the transaction is abandoned with no response and no `last` update.
- Latency: accept at edge E0 → capture at edge E0 + 1 + `ALU_LATENCY` → `rspN_valid` high in the following cycle.
- Throughput, with responses consumed immediately: one transaction per `ALU_LATENCY` + 3 cycles.
- `reqN_ready` is high only in IDLE, for at most one cycle per transaction.
- Simultaneous valid: round-robin as described. With both channels continuously valid, grants alternate 0, 1, 0, 1.
- Request edge cases:
  - A request that arrives while the block is busy waits and is granted in the next IDLE.
  - `valid` deasserted before acceptance is legal. No grant is issued for it.

## Test plan
Bench ALU stub: {carry, alu_out} = a + b, with `ALU_LATENCY` pipeline stages.
- Single ch0 request, opcode 8'h01, a = 200, b = 100, `ALU_LATENCY` = 0 → `req0_ready` pulses once; `rsp0_data` = 44, `rsp0_carry` = 1, `rsp0_valid` in cycle E0 + 2; `rsp1_valid` stays 0.
- Both channels valid on the first cycle after reset: ch0 a = 1, b = 2 and ch1 a = 3, b = 4 → ch0 is granted first (result 3), then ch1 (result 7); `grant_id` sequence 0, 1.
- Both channels continuously valid for 6 transactions → grants alternate 0, 1, 0, 1, 0, 1; each response matches its channel's operands.
- `rsp0_ready` held low for 5 cycles during RESP → `rsp0_data` and `rsp0_carry` stay stable; `req1_ready` stays 0 throughout; ch1 is accepted in the first IDLE after the handshake.
- `ALU_LATENCY` = 2, a = 255, b = 1 → `rsp_valid` in cycle E0 + 4; data 0, carry 1; `operand_a` and `operand_b` held stable through WAIT.
- `RESET` asserted for 1 cycle during WAIT → no `rsp_valid` on either channel; all outputs are 0 the next cycle; the next request is served normally with ch0 priority.
